// File: rtl/ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control-signal pipeline:
//   - stage index names (E/M/W)
//   - the default bundle width
//   - bit offsets of the MIPS control bundle, so every consumer slices a
//     stage's ctrl_out word the same way
// -----------------------------------------------------------------------------
package ctrl_pipe_pkg;

    // Stage indices; wide enough for the largest legal pipeline (8 stages).
    typedef enum logic [2:0] {
        STG_E = 3'd0,
        STG_M = 3'd1,
        STG_W = 3'd2
    } stage_e;

    localparam int CTRL_W_DEFAULT = 32;

    // Bit positions inside one control bundle word.
    localparam int OFS_MEMTOREG   = 0;
    localparam int OFS_MEMWRITE   = 1;
    localparam int OFS_MEMEN      = 2;
    localparam int OFS_ALUSRC     = 3;
    localparam int OFS_REGDST     = 4;
    localparam int OFS_REGWRITE   = 5;
    localparam int OFS_ALUCONTROL = 6;   // alucontrol[7:0] occupies bits 13:6
    localparam int W_ALUCONTROL   = 8;
    localparam int OFS_HILO_WRITE = 14;
    localparam int OFS_JAL        = 15;
    localparam int OFS_JR         = 16;
    localparam int OFS_BAL        = 17;

endpackage

// File: rtl/ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_if
// Decode-to-pipeline handshake.
//   in_ctrl  : control bundle produced by the decoders
//   in_valid : decode slot holds a real instruction
//   in_ready : pipeline accepts the decode slot this cycle
// master = decode side, slave = ctrl_pipe.
// -----------------------------------------------------------------------------
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = CTRL_W_DEFAULT
);
    logic [WIDTH-1:0] in_ctrl;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_ctrl,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_ctrl,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_stage
// One pipeline slot: a WIDTH-bit control bundle plus its valid bit.
// Update priority on each rising edge: flush > hold > bubble > load.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   src_ctrl/src_valid : contents offered by the previous slot (or decode)
//   flush              : clear this slot
//   hold               : keep current contents (effective stall)
//   bubble             : previous slot is frozen, so insert an empty slot
//   ctrl_q/valid_q     : registered slot contents
// -----------------------------------------------------------------------------
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = CTRL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_ctrl,
    input  logic             src_valid,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    output logic [WIDTH-1:0] ctrl_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] ctrl_d;
    logic             valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (bubble) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            // An empty slot always carries an all-zero bundle, so stray
            // decoder outputs never reach the datapath.
            valid_d = src_valid;
            ctrl_d  = src_valid ? src_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Carries the decoded control bundle through STAGES slots (E/M/W by default)
// with per-stage valid, stall back-pressure, bubble insertion, per-stage and
// global flush, and an in-flight count.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   dec        : decode handshake (in_ctrl, in_valid, in_ready)
//   stall      : raw stall request per stage
//   flush      : flush request per stage
//   flush_all  : flush every stage
//   ctrl_out   : stage i bundle at [i*WIDTH +: WIDTH]
//   valid_out  : per-stage valid
//   inflight   : number of valid stages
// -----------------------------------------------------------------------------
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH  = CTRL_W_DEFAULT,
    parameter int STAGES = 3,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    ctrl_pipe_if.slave              dec,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    flush_all,
    output logic [STAGES*WIDTH-1:0] ctrl_out,
    output logic [STAGES-1:0]       valid_out,
    output logic [CNT_W-1:0]        inflight
);

    // A stage is effectively stalled if it or any younger-numbered (further
    // downstream) stage requests a stall; computed as an OR over the upper
    // bits so there is no bit-to-bit combinational chain.
    logic [STAGES-1:0] es;

    always_comb begin
        es = '0;
        for (int i = 0; i < STAGES; i++) begin
            es[i] = |(stall >> i);
        end
    end

    // Ready depends on stall only: a flushed stage 0 still accepts next cycle.
    assign dec.in_ready = ~es[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] src_ctrl;
        logic             src_valid;
        logic             bubble;

        if (g == 0) begin : g_head
            assign src_ctrl  = dec.in_ctrl;
            assign src_valid = dec.in_valid;
            assign bubble    = 1'b0;
        end else begin : g_body
            // Reads the pre-edge register of the previous stage, so a flush
            // of stage g-1 on the same edge still hands its contents on.
            assign src_ctrl  = ctrl_out[(g-1)*WIDTH +: WIDTH];
            assign src_valid = valid_out[g-1];
            assign bubble    = es[g-1];
        end

        ctrl_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .src_ctrl  (src_ctrl),
            .src_valid (src_valid),
            .flush     (flush_all | flush[g]),
            .hold      (es[g]),
            .bubble    (bubble),
            .ctrl_q    (ctrl_out[g*WIDTH +: WIDTH]),
            .valid_q   (valid_out[g])
        );
    end

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + CNT_W'(valid_out[i]);
        end
    end

    assign inflight = cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed bench for ctrl_pipe (WIDTH=32, STAGES=3). Each stimulus cycle pushes
// the hand-computed post-edge state into a queue; a separate monitor pops and
// compares after each rising edge (or immediately, for the async reset case).
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int CNT_W  = $clog2(STAGES + 1);

    typedef struct {
        string        name;
        logic [95:0]  ctrl;
        logic [2:0]   vld;
        int           inf;
        logic         rdy;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic                    flush_all;
    logic [STAGES*WIDTH-1:0] ctrl_out;
    logic [STAGES-1:0]       valid_out;
    logic [CNT_W-1:0]        inflight;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    event sample_ev;

    ctrl_pipe_if #(.WIDTH(WIDTH)) dec_if ();

    ctrl_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec       (dec_if),
        .stall     (stall),
        .flush     (flush),
        .flush_all (flush_all),
        .ctrl_out  (ctrl_out),
        .valid_out (valid_out),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue the state
    // expected after the following rising edge. With now=1 the monitor is
    // woken immediately instead (asynchronous reset).
    task automatic cyc(input string name, input logic r,
                       input logic [31:0] ic, input logic iv,
                       input logic [2:0] st, input logic [2:0] fl, input logic fa,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [2:0] ev, input int einf, input logic erdy,
                       input bit now = 1'b0);
        exp_t e;
        @(negedge clk);
        rst             = r;
        dec_if.in_ctrl  = ic;
        dec_if.in_valid = iv;
        stall           = st;
        flush           = fl;
        flush_all       = fa;
        e.name = name;
        e.ctrl = {e2, e1, e0};
        e.vld  = ev;
        e.inf  = einf;
        e.rdy  = erdy;
        sb_q.push_back(e);
        if (now) -> sample_ev;
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (ctrl_out !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl_out got %h want %h", e.name, ctrl_out, e.ctrl);
                end
                checks++;
                if (valid_out !== e.vld) begin
                    errors++;
                    $display("FAIL %s valid_out got %b want %b", e.name, valid_out, e.vld);
                end
                checks++;
                if (int'(inflight) != e.inf || $isunknown(inflight)) begin
                    errors++;
                    $display("FAIL %s inflight got %0d want %0d", e.name, inflight, e.inf);
                end
                checks++;
                if (dec_if.in_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL %s in_ready got %b want %b", e.name, dec_if.in_ready, e.rdy);
                end
            end
        end
    end

    initial begin
        rst             = 1'b0;
        dec_if.in_ctrl  = '0;
        dec_if.in_valid = 1'b0;
        stall           = '0;
        flush           = '0;
        flush_all       = 1'b0;
        checks          = 0;
        errors          = 0;

        //  name            rst ic            iv  st      fl      fa    e0            e1           e2           ev      inf rdy
        cyc("reset_hold",   0, 32'h0,         0, 3'b000, 3'b000, 0,   32'h0,        32'h0,       32'h0,       3'b000, 0, 1);
        cyc("rst_release",  1, 32'hA5,        1, 3'b000, 3'b000, 0,   32'hA5,       32'h0,       32'h0,       3'b001, 1, 1);
        cyc("sanitize",     1, 32'hFFFF_FFFF, 0, 3'b000, 3'b000, 0,   32'h0,        32'hA5,      32'h0,       3'b010, 1, 1);
        cyc("flow_a",       1, 32'h1,         1, 3'b000, 3'b000, 0,   32'h1,        32'h0,       32'hA5,      3'b101, 2, 1);
        cyc("flow_b",       1, 32'h2,         1, 3'b000, 3'b000, 0,   32'h2,        32'h1,       32'h0,       3'b011, 2, 1);
        cyc("flow_c",       1, 32'h3,         1, 3'b000, 3'b000, 0,   32'h3,        32'h2,       32'h1,       3'b111, 3, 1);
        cyc("stall_m",      1, 32'h4,         1, 3'b010, 3'b000, 0,   32'h3,        32'h2,       32'h0,       3'b011, 2, 0);
        cyc("resume",       1, 32'h4,         1, 3'b000, 3'b000, 0,   32'h4,        32'h3,       32'h2,       3'b111, 3, 1);
        cyc("flush_stall_e",1, 32'h5,         1, 3'b001, 3'b001, 0,   32'h0,        32'h0,       32'h3,       3'b100, 1, 0);
        cyc("refill",       1, 32'h6,         1, 3'b000, 3'b000, 0,   32'h6,        32'h0,       32'h0,       3'b001, 1, 1);
        cyc("flush_e_fwd",  1, 32'h7,         1, 3'b000, 3'b001, 0,   32'h0,        32'h6,       32'h0,       3'b010, 1, 1);
        cyc("after_flush",  1, 32'h8,         1, 3'b000, 3'b000, 0,   32'h8,        32'h0,       32'h6,       3'b101, 2, 1);
        cyc("fill_9",       1, 32'h9,         1, 3'b000, 3'b000, 0,   32'h9,        32'h8,       32'h0,       3'b011, 2, 1);
        cyc("fill_10",      1, 32'h10,        1, 3'b000, 3'b000, 0,   32'h10,       32'h9,       32'h8,       3'b111, 3, 1);
        cyc("stall_w",      1, 32'h11,        1, 3'b100, 3'b000, 0,   32'h10,       32'h9,       32'h8,       3'b111, 3, 0);
        cyc("flush_all",    1, 32'h11,        1, 3'b111, 3'b000, 1,   32'h0,        32'h0,       32'h0,       3'b000, 0, 0);
        cyc("post_flush",   1, 32'h12,        1, 3'b000, 3'b000, 0,   32'h12,       32'h0,       32'h0,       3'b001, 1, 1);
        cyc("fill_13",      1, 32'h13,        1, 3'b000, 3'b000, 0,   32'h13,       32'h12,      32'h0,       3'b011, 2, 1);
        cyc("fill_14",      1, 32'h14,        1, 3'b000, 3'b000, 0,   32'h14,       32'h13,      32'h12,      3'b111, 3, 1);
        cyc("async_rst",    0, 32'h15,        1, 3'b000, 3'b000, 0,   32'h0,        32'h0,       32'h0,       3'b000, 0, 1, 1'b1);
        cyc("rst_held",     0, 32'h15,        1, 3'b000, 3'b000, 0,   32'h0,        32'h0,       32'h0,       3'b000, 0, 1);
        cyc("rst_release2", 1, 32'hA5,        1, 3'b000, 3'b000, 0,   32'hA5,       32'h0,       32'h0,       3'b001, 1, 1);

        // Let the monitor drain the queue, within a bounded number of edges.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending got %0d want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised control-signal pipeline that carries the decoded control bundle from decode through STAGES downstream stages (default E/M/W). It replaces fixed per-stage enable/clear registers with a generic chain that adds:
- a valid bit per stage
- stall back-pressure propagation
- automatic bubble insertion
- per-stage and global flush
- an in-flight count
It sits between the main/ALU decoders and the execute/memory/writeback datapath.

Parameters:
WIDTH, 32, width of the opaque control bundle per stage (bits)
STAGES, 3, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W); legal range 1..8
CNT_W, $clog2(STAGES+1), width of in-flight count output (derived)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
in_ctrl  input  WIDTH  control bundle from decode
in_valid  input  1  decode slot holds a real instruction
in_ready  output  1  decode may advance this cycle (= ~es[0])
stall  input  STAGES  raw stall request per stage, bit i = stage i
flush  input  STAGES  flush request per stage, bit i = stage i
flush_all  input  1  exception/redirect flush of every stage
ctrl_out  output  STAGES*WIDTH  stage i bundle at bits [i*WIDTH +: WIDTH]
valid_out  output  STAGES  per-stage valid
inflight  output  CNT_W  number of set bits in valid_out

Behaviour:
- Reset (rst=0, async): all ctrl_out=0, valid_out=0, inflight=0. This holds regardless of clk; release is synchronous to the next edge.
- Effective stall (combinational):
  - es[STAGES-1] = stall[STAGES-1].
  - es[i] = stall[i] | es[i+1].
  - A stalled stage therefore freezes every older stage.
- Source of stage i: stage 0 takes in_ctrl/in_valid; stage i>0 takes stage i-1 registers.
- Per-stage update at posedge, in priority order:
  1. flush_all | flush[i] -> valid=0, ctrl=0. Flush beats stall.
  2. es[i] -> hold.
  3. i>0 and es[i-1] -> bubble: valid=0, ctrl=0.
  4. Otherwise load source.
- Invariant: ctrl of a stage is all-zero whenever its valid=0. Loading in_valid=0 stores ctrl=0 even if in_ctrl≠0.
- Latency: an instruction accepted at edge n (in_valid=1, in_ready=1) appears on stage k at edge n+k when no stalls occur.
- in_ready is combinational from stall only, not from flush. A flushed stage 0 still accepts the next cycle.
- Simultaneous flush[i] and stall[i]: stage i clears. Older stages still hold, because es is unaffected by flush.
- flush[i] while stage i+1 is loading: stage i+1 receives the pre-flush contents of stage i on that same edge. Flush affects only the register of stage i.
- inflight: combinational popcount of valid_out, range 0..STAGES.
- All ctrl_out/valid_out outputs are registered; no combinational path from in_ctrl to outputs.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - stage index constants STG_E=0, STG_M=1, STG_W=2
  - default WIDTH
  - bundle field offsets for the MIPS control bundle (memtoreg, memwrite, memen, alusrc, regdst, regwrite, alucontrol[7:0], hilo_write, jal, jr, bal), so users slice ctrl_out consistently
- One sub-module, ctrl_pipe_stage: a single WIDTH+1-bit slice with flush/hold/bubble/load priority. It is instantiated STAGES times in a generate loop. The top computes es[] and inflight.

Test Plan:
- Reset: drive rst=0 mid-stream with all stages valid -> outputs 0 immediately (async), inflight=0. Release, in_ctrl=32'hA5 valid -> stage 0 = 32'hA5 at the next edge.
- Free flow: inject A=1, B=2, C=3 on consecutive cycles, no stalls -> edge 3: stage0=C, stage1=B, stage2=A, inflight=3.
- Stall M (stall=3'b010) one cycle with pipeline A/B/C -> stages 0 and 1 hold C/B, stage 2 becomes bubble (valid 0, ctrl 0), in_ready=0. Next edge resumes: stage2=B.
- Flush vs stall: stall=3'b001, flush=3'b001 on stage0=C -> stage0 clears to 0/invalid, in_ready=0; new in_ctrl=4 loads the next unstalled cycle.
- flush_all with A/B/C in flight and stall=3'b111 -> all valid 0, ctrl 0, inflight=0 after one edge.
- Sanitize: in_valid=0 with in_ctrl=32'hFFFF_FFFF -> stage 0 ctrl=0, valid=0.
